if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch front end for the MIPS pipeline. It generates sequential PCs, issues pipelined word requests to instruction memory, and buffers returned words in a DEPTH-entry FIFO. It presents up to ISSUE_W instructions per cycle to decode. Exception, ERET and branch/jump redirects carry fixed priority; a redirect flushes the FIFO and squashes in-flight responses. A halted state handles misaligned PCs (AdEL).

## Interface
Parameters:
- ISSUE_W, 2, decode lanes per cycle (1..4)
- DEPTH, 8, FIFO entries (power of 2, ≥ 2·ISSUE_W)
- MAX_OUT, 2, max accepted-but-unanswered memory requests (1..4)
- RESET_PC, 32'hBFC0_0000, fetch address after reset
- EXC_VEC, 32'hBFC0_0380, exception entry address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_stall  in  1  freeze new request issue; FIFO pops still allowed
- exc_req  in  1  exception redirect to EXC_VEC
- eret_req  in  1  redirect to cp0_epc
- cp0_epc  in  32  ERET target
- br_req  in  1  branch/jump redirect; decode asserts it after the delay slot has been accepted
- br_target  in  32  branch/jump target
- imem_req  out  1  request valid
- imem_addr  out  32  word address of request
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  in-order response valid
- imem_rdata  in  32  response word
- id_valid  out  ISSUE_W  lane k valid iff FIFO occupancy > k
- id_inst  out  32·ISSUE_W  lane k = bits [32k+31:32k], oldest in lane 0
- id_pc  out  32·ISSUE_W  PC of each lane
- id_adel  out  ISSUE_W  lane holds misaligned-fetch marker
- id_accept  in  clog2(ISSUE_W+1)  number of lanes decode consumes this cycle

## Operation
- State: fetch_pc, FIFO (rd/wr pointers, count), out_cnt (outstanding requests), stale_cnt (responses to discard), halted flag.
- Redirect target priority: exc_req > eret_req > br_req. Exactly one target is taken per cycle.
- Issue condition: imem_req=1 when !reset, !fetch_stall, !halted, no redirect this cycle, out_cnt < MAX_OUT, and count + out_cnt < DEPTH. imem_addr = fetch_pc.
- Once imem_req is raised, it and imem_addr stay stable until gnt. Exception: a redirect may withdraw or retarget them.
- Handshake (imem_req & imem_gnt): fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC → 0), out_cnt++.
- Response: if stale_cnt > 0, drop the word and decrement stale_cnt. Otherwise push {imem_rdata, pc, adel=0} and decrement out_cnt. The pc for each entry is tracked in a parallel MAX_OUT-deep PC queue.
- Misaligned PC (fetch_pc[1:0] ≠ 0) with no outstanding requests: no memory request is issued. The unit pushes {inst=0, pc=fetch_pc, adel=1} once and sets halted. Only a redirect or reset clears halted.
- Pop: remove id_accept entries. id_accept > occupancy is illegal; an assertion checks it.
- Redirect (any req) in cycle t:
  - FIFO cleared.
  - stale_cnt += out_cnt, plus 1 if a handshake also completes in cycle t.
  - out_cnt cleared.
  - halted cleared.
  - fetch_pc = target.
  - Any response in cycle t is discarded.
  - id_accept in cycle t is ignored.
- Simultaneous push and pop in the same cycle: both take effect. A full FIFO still accepts the push when a pop occurs in the same cycle.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - id_valid=0, id_inst=0, id_pc=0, id_adel=0
  - fetch_pc=RESET_PC
  - count, out_cnt, stale_cnt all 0; halted=0
- First imem_req is asserted in the first cycle after reset deasserts.
- Reset mid-transaction clears all counters. The memory must be reset in the same cycle; responses arriving after reset are undefined.
- imem_req is a registered-free function of state. It is never asserted in a redirect cycle; the earliest request to the new target is at t+1.
- Latency: a response pushed in cycle t appears on id_valid in cycle t+1. There is no bypass.
- Throughput: with 1-cycle memory and MAX_OUT ≥ 2, the unit sustains 1 word/cycle.
- fetch_stall takes effect in the same cycle: imem_req drops unless a request is already pending without gnt.

## Test plan
- Reset, gnt always 1, rvalid one cycle after gnt, id_accept=0 → words from addresses BFC0_0000, _0004, … fill the FIFO. Issue stops when count+out_cnt=8. id_pc lane0=BFC0_0000, lane1=BFC0_0004.
- Steady state with id_accept=2 each cycle (ISSUE_W=2) → no FIFO overflow or underflow; PCs contiguous; imem_req throttles correctly.
- With out_cnt=2, raise br_req with br_target=8000_0100 → next two rvalid words dropped; id_valid=0 at t+1; first new entry carries pc 8000_0100.
- exc_req, eret_req (cp0_epc=8000_0200) and br_req asserted in the same cycle → next fetch addresses BFC0_0380. Then eret alone → 8000_0200.
- br_target=8000_0102 → no memory request; one entry with id_adel=1 and pc 8000_0102; the unit stays halted. exc_req → fetch resumes at BFC0_0380.
- fetch_stall held for 5 cycles while the FIFO drains → imem_req stays 0. On release, fetch resumes at the next sequential PC with no duplicated and no skipped PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS instruction-fetch front end
// Sequential PC issue to imem, DEPTH-entry decode FIFO, prioritised redirects and AdEL halt.
module if_fetch_unit #(
   parameter int          ISSUE_W  = 2,
   parameter int          DEPTH    = 8,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_stall,
   input  logic                           exc_req,
   input  logic                           eret_req,
   input  logic [31:0]                    cp0_epc,
   input  logic                           br_req,
   input  logic [31:0]                    br_target,
   output logic                           imem_req,
   output logic [31:0]                    imem_addr,
   input  logic                           imem_gnt,
   input  logic                           imem_rvalid,
   input  logic [31:0]                    imem_rdata,
   output logic [ISSUE_W-1:0]             id_valid,
   output logic [32*ISSUE_W-1:0]          id_inst,
   output logic [32*ISSUE_W-1:0]          id_pc,
   output logic [ISSUE_W-1:0]             id_adel,
   input  logic [$clog2(ISSUE_W+1)-1:0]   id_accept
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int SUM_W   = CNT_W + 1;
   localparam int OUT_W   = 3;
   localparam int STALE_W = 8;
   localparam int ACC_W   = $clog2(ISSUE_W + 1);
   localparam int PQ_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
   logic               halted_q, halted_d;
   logic               pend_q, pend_d;
   logic [PQ_W-1:0]    pq_rd_q, pq_rd_d;
   logic [PQ_W-1:0]    pq_wr_q, pq_wr_d;

   logic [31:0]        pq_mem_q    [MAX_OUT];
   logic [31:0]        fifo_inst_q [DEPTH];
   logic [31:0]        fifo_pc_q   [DEPTH];
   logic               fifo_adel_q [DEPTH];

   logic               redirect;
   logic [31:0]        redir_pc;
   logic               can_issue;
   logic               hs;
   logic               rsp_stale;
   logic               rsp_fresh;
   logic               adel_push;
   logic               push;
   logic [31:0]        push_inst;
   logic [31:0]        push_pc;
   logic               push_adel;
   logic [CNT_W-1:0]   pop_n;

   function automatic logic [PQ_W-1:0] pq_inc(input logic [PQ_W-1:0] p);
      return (p == PQ_W'(MAX_OUT - 1)) ? '0 : p + PQ_W'(1);
   endfunction

   always_comb begin
      redirect = exc_req | eret_req | br_req;
      redir_pc = br_target;
      if (exc_req) begin
         redir_pc = EXC_VEC;
      end else if (eret_req) begin
         redir_pc = cp0_epc;
      end

      can_issue = !fetch_stall && !halted_q && (fetch_pc_q[1:0] == 2'b00)
                  && (out_cnt_q < OUT_W'(MAX_OUT))
                  && ((SUM_W'(count_q) + SUM_W'(out_cnt_q)) < SUM_W'(DEPTH));
      // An offered but ungranted request stays up through a stall
      imem_req  = !reset && !redirect && (pend_q || can_issue);
      imem_addr = fetch_pc_q;
      hs        = imem_req && imem_gnt;

      rsp_stale = imem_rvalid && (stale_cnt_q != '0);
      rsp_fresh = imem_rvalid && (stale_cnt_q == '0) && !redirect;
      pop_n     = redirect ? '0 : CNT_W'(id_accept);
      adel_push = !redirect && !halted_q && (fetch_pc_q[1:0] != 2'b00)
                  && (out_cnt_q == '0)
                  && ((count_q != CNT_W'(DEPTH)) || (pop_n != '0));
      push      = rsp_fresh || adel_push;
      push_inst = rsp_fresh ? imem_rdata : 32'h0;
      push_pc   = rsp_fresh ? pq_mem_q[pq_rd_q] : fetch_pc_q;
      push_adel = !rsp_fresh;
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      out_cnt_d   = out_cnt_q;
      stale_cnt_d = stale_cnt_q;
      halted_d    = halted_q;
      pq_rd_d     = pq_rd_q;
      pq_wr_d     = pq_wr_q;
      pend_d      = imem_req && !imem_gnt;

      if (redirect) begin
         fetch_pc_d  = redir_pc;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         out_cnt_d   = '0;
         halted_d    = 1'b0;
         pq_rd_d     = '0;
         pq_wr_d     = '0;
         // Every in-flight request becomes stale; a response this cycle retires one of them
         stale_cnt_d = stale_cnt_q + STALE_W'(out_cnt_q) + STALE_W'(hs)
                       - STALE_W'(imem_rvalid);
      end else begin
         if (hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pq_wr_d    = pq_inc(pq_wr_q);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rsp_fresh) begin
            pq_rd_d = pq_inc(pq_rd_q);
         end
         if (rsp_stale) begin
            stale_cnt_d = stale_cnt_q - STALE_W'(1);
         end
         if (adel_push) begin
            halted_d = 1'b1;
         end
         rd_ptr_d  = rd_ptr_q + PTR_W'(pop_n);
         count_d   = count_q + CNT_W'(push) - pop_n;
         out_cnt_d = out_cnt_q + OUT_W'(hs) - OUT_W'(rsp_fresh);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q  <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_cnt_q   <= '0;
         stale_cnt_q <= '0;
         halted_q    <= 1'b0;
         pend_q      <= 1'b0;
         pq_rd_q     <= '0;
         pq_wr_q     <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         out_cnt_q   <= out_cnt_d;
         stale_cnt_q <= stale_cnt_d;
         halted_q    <= halted_d;
         pend_q      <= pend_d;
         pq_rd_q     <= pq_rd_d;
         pq_wr_q     <= pq_wr_d;
      end
   end

   // Storage arrays need no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_inst_q[wr_ptr_q] <= push_inst;
         fifo_pc_q[wr_ptr_q]   <= push_pc;
         fifo_adel_q[wr_ptr_q] <= push_adel;
      end
      if (hs) begin
         pq_mem_q[pq_wr_q] <= fetch_pc_q;
      end
   end

   always_comb begin
      id_valid = '0;
      id_inst  = '0;
      id_pc    = '0;
      id_adel  = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         logic [PTR_W-1:0] idx;
         logic             lane_ok;
         idx     = rd_ptr_q + PTR_W'(k);
         lane_ok = count_q > CNT_W'(k);
         id_valid[k] = lane_ok;
         if (lane_ok) begin
            id_inst[32*k +: 32] = fifo_inst_q[idx];
            id_pc[32*k +: 32]   = fifo_pc_q[idx];
            id_adel[k]          = fifo_adel_q[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !redirect) begin
         assert ((CNT_W'(id_accept) <= count_q) && (id_accept <= ACC_W'(ISSUE_W)));
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_stall;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] cp0_epc;
   logic        br_req;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [1:0]  id_valid;
   logic [63:0] id_inst;
   logic [63:0] id_pc;
   logic [1:0]  id_adel;
   logic [1:0]  id_accept;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_stall(fetch_stall),
      .exc_req(exc_req), .eret_req(eret_req), .cp0_epc(cp0_epc),
      .br_req(br_req), .br_target(br_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_adel(id_adel), .id_accept(id_accept)
   );

   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          cyc    = 0;
   int          lat    = 1;
   int          hs_cnt = 0;
   bit          hold   = 1'b0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] q_addr[$];
   int          q_due[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic mem_drive();
      imem_rvalid = !hold && (q_addr.size() > 0) && (q_due[0] <= cyc);
      imem_rdata  = imem_rvalid ? mem_word(q_addr[0]) : 32'h0;
   endtask

   task automatic tick();
      logic        h;
      logic        r;
      logic [31:0] a;
      @(negedge clk);
      h = imem_req & imem_gnt;
      a = imem_addr;
      r = imem_rvalid;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      if (h) begin
         q_addr.push_back(a);
         q_due.push_back(cyc + lat - 1);
         hs_cnt++;
      end
      mem_drive();
   endtask

   task automatic consume();
      int n;
      n = id_valid[1] ? 2 : (id_valid[0] ? 1 : 0);
      for (int k = 0; k < n; k++) begin
         chk("lane_pc", {32'h0, id_pc[32*k +: 32]}, {32'h0, exp_pc});
         chk("lane_inst", {32'h0, id_inst[32*k +: 32]}, {32'h0, mem_word(exp_pc)});
         exp_pc = exp_pc + 32'd4;
      end
      id_accept = 2'(n);
   endtask

   task automatic mem_clear();
      q_addr.delete();
      q_due.delete();
      mem_drive();
   endtask

   initial begin
      reset = 1'b1; fetch_stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
      cp0_epc = 32'h0; br_req = 1'b0; br_target = 32'h0; imem_gnt = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; id_accept = 2'd0;
      tick();
      tick();
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 32'hBFC0_0000);
      chk("rst_valid", id_valid, 0);
      chk("rst_inst", id_inst, 0);
      chk("rst_pc", id_pc, 0);
      chk("rst_adel", id_adel, 0);

      reset = 1'b0; hs_cnt = 0; mem_clear(); #1;
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 32'hBFC0_0000);
      repeat (12) tick();
      chk("fill_hs", hs_cnt, 8);
      chk("fill_req", imem_req, 0);
      chk("fill_valid", id_valid, 2'b11);
      chk("fill_pc0", id_pc[31:0], 32'hBFC0_0000);
      chk("fill_pc1", id_pc[63:32], 32'hBFC0_0004);
      chk("fill_inst0", id_inst[31:0], mem_word(32'hBFC0_0000));

      exp_pc = 32'hBFC0_0000;
      repeat (20) begin
         consume();
         tick();
      end
      id_accept = 2'd0;
      chk("steady_progress", exp_pc, 32'hBFC0_0064);

      reset = 1'b1; #1;
      tick();
      reset = 1'b0; hold = 1'b1; mem_clear(); #1;
      tick();
      tick();
      chk("maxout_req", imem_req, 0);
      br_req = 1'b1; br_target = 32'h8000_0100; #1;
      chk("br_noreq", imem_req, 0);
      tick();
      br_req = 1'b0; hold = 1'b0; mem_drive(); #1;
      chk("br_flush", id_valid, 0);
      chk("br_req1", imem_req, 1);
      chk("br_addr", imem_addr, 32'h8000_0100);
      tick();
      chk("drop1", id_valid, 0);
      tick();
      chk("drop2", id_valid, 0);
      tick();
      chk("new_valid", id_valid[0], 1);
      chk("new_pc", id_pc[31:0], 32'h8000_0100);
      chk("new_inst", id_inst[31:0], mem_word(32'h8000_0100));

      exc_req = 1'b1; eret_req = 1'b1; br_req = 1'b1;
      cp0_epc = 32'h8000_0200; br_target = 32'h8000_0300; #1;
      chk("prio_noreq", imem_req, 0);
      tick();
      exc_req = 1'b0; eret_req = 1'b0; br_req = 1'b0; #1;
      chk("prio_addr", imem_addr, 32'hBFC0_0380);
      chk("prio_req", imem_req, 1);
      chk("prio_flush", id_valid, 0);
      tick();
      eret_req = 1'b1; #1;
      chk("eret_noreq", imem_req, 0);
      tick();
      eret_req = 1'b0; #1;
      chk("eret_addr", imem_addr, 32'h8000_0200);
      chk("eret_req", imem_req, 1);

      br_req = 1'b1; br_target = 32'h8000_0102; #1;
      tick();
      br_req = 1'b0; #1;
      chk("adel_noreq", imem_req, 0);
      tick();
      chk("adel_valid", id_valid, 2'b01);
      chk("adel_flag", id_adel, 2'b01);
      chk("adel_pc", id_pc[31:0], 32'h8000_0102);
      chk("adel_inst", id_inst[31:0], 32'h0);
      repeat (3) tick();
      chk("halt_valid", id_valid, 2'b01);
      chk("halt_req", imem_req, 0);
      exc_req = 1'b1; #1;
      tick();
      exc_req = 1'b0; #1;
      chk("resume_addr", imem_addr, 32'hBFC0_0380);
      chk("resume_req", imem_req, 1);
      chk("resume_flush", id_valid, 0);

      exp_pc = 32'hBFC0_0380;
      repeat (4) tick();
      fetch_stall = 1'b1; #1;
      repeat (5) begin
         chk("stall_req", imem_req, 0);
         consume();
         tick();
      end
      fetch_stall = 1'b0; #1;
      chk("stall_drained", exp_pc, 32'hBFC0_0390);
      chk("unstall_req", imem_req, 1);
      chk("unstall_addr", imem_addr, 32'hBFC0_0390);
      repeat (8) begin
         consume();
         tick();
      end
      id_accept = 2'd0;
      chk("unstall_progress", exp_pc, 32'hBFC0_03A8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
